// File: rtl/uart_pixel_tx_pkg.sv
// Shared types and defaults for the pixel UART transmitter and its FIFO.
package definitions_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} uart_tx_state_t;

  typedef logic [7:0] pixel_t;

  localparam int UART_CLKS_PER_BIT = 32;

endpackage

// File: rtl/uart_pixel_tx_fifo.sv
// Synchronous circular pixel buffer with first-word fall-through read data.
module pixel_fifo
  import definitions_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  pixel_t                       wdata,
  output pixel_t                       rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on push only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign count = count_q;

endmodule

// File: rtl/uart_pixel_tx.sv
// 8N1 UART transmitter for processed pixels, fed from a small pixel FIFO.
module uart_pixel_tx
  import definitions_pkg::*;
#(
  parameter int CLKS_PER_BIT  = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH    = 16,
  parameter int IDLE_GAP_BITS = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        pixel_data,
  input  logic                              pixel_valid,
  output logic                              pixel_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYCLES = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  uart_tx_state_t     state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  pixel_t             shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               push_s, pop_s, frame_end_s, baud_last_s;
  logic               fifo_full_s, fifo_empty_s;
  pixel_t             fifo_rdata_s;

  assign pixel_ready = !fifo_full_s && !rst;
  assign push_s      = pixel_valid && pixel_ready;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pixel_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  // Frame sequencing: tx is computed one cycle ahead so the pin is a flop output.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    pop_s       = 1'b0;
    frame_end_s = 1'b0;
    baud_last_s = (baud_q == BAUD_LAST);
    case (state_q)
      TX_IDLE: begin
        tx_d        = 1'b1;
        frame_end_s = 1'b1;
      end
      TX_START: begin
        if (baud_last_s) begin
          baud_d    = BAUD_W'(0);
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_last_s) begin
          baud_d    = BAUD_W'(0);
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_last_s) begin
          baud_d = BAUD_W'(0);
          if (IDLE_GAP_BITS == 0) begin
            frame_end_s = 1'b1;
          end else begin
            state_d = TX_GAP;
            gap_d   = GAP_W'(0);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      TX_GAP: begin
        if (gap_q == GAP_LAST) begin
          frame_end_s = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // The last cycle of a frame doubles as IDLE so queued pixels go out back-to-back.
    if (frame_end_s) begin
      if (!fifo_empty_s) begin
        pop_s   = 1'b1;
        shift_d = fifo_rdata_s;
        baud_d  = BAUD_W'(0);
        state_d = TX_START;
        tx_d    = 1'b0;
      end else begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
    busy_d = (state_d != TX_IDLE);
  end

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      baud_q    <= BAUD_W'(0);
      bit_idx_q <= 3'd0;
      gap_q     <= GAP_W'(0);
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_pixel_tx.sv
// Self-checking bench: default instance plus a fast small-FIFO variant, both scoreboarded.
module tb_uart_pixel_tx;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] pd_a, pd_b;
  logic       pv_a, pv_b, pr_a, pr_b, tx_a, tx_b, busy_a, busy_b;
  logic [4:0] cnt_a;
  logic [1:0] cnt_b;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         starts_a[$];
  int         starts_b[$];
  logic       mon_busy_a = 1'b0;
  logic       mon_busy_b = 1'b0;
  int         last_low_a = 0;

  uart_pixel_tx dut_a (
    .clk(clk), .rst(rst_a), .pixel_data(pd_a), .pixel_valid(pv_a), .pixel_ready(pr_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  uart_pixel_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(2), .IDLE_GAP_BITS(0)) dut_b (
    .clk(clk), .rst(rst_b), .pixel_data(pd_b), .pixel_valid(pv_b), .pixel_ready(pr_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame decoder: compares every cycle of a frame against the scoreboard byte.
  task automatic mon(input int which, input int c, input int g);
    logic [7:0] d;
    logic [9:0] obs;
    logic       txv, rv, expb, aborted;
    int         bad, low, bitn, nf;
    nf = (10 + g) * c;
    forever begin
      @(negedge clk);
      txv = (which == 0) ? tx_a : tx_b;
      rv  = (which == 0) ? rst_a : rst_b;
      if (txv === 1'b0 && rv === 1'b0) begin
        if (which == 0) begin
          mon_busy_a = 1'b1;
          starts_a.push_back(cyc);
        end else begin
          mon_busy_b = 1'b1;
          starts_b.push_back(cyc);
        end
        d = 8'h00;
        if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
          vectors++;
          miscompares++;
          $error("FAIL unexpected_frame: dut %0d started a frame at cycle %0d, required none", which, cyc);
        end else if (which == 0) begin
          d = qa.pop_front();
        end else begin
          d = qb.pop_front();
        end
        bad = 0; low = 0; obs = 10'h000; aborted = 1'b0;
        for (int i = 0; i < nf; i++) begin
          if (i > 0) begin
            @(negedge clk);
            txv = (which == 0) ? tx_a : tx_b;
            rv  = (which == 0) ? rst_a : rst_b;
          end
          if (rv === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bitn = i / c;
          expb = (bitn == 0) ? 1'b0 : ((bitn <= 8) ? d[bitn-1] : 1'b1);
          if (txv !== expb) bad++;
          if (txv === 1'b0) low++;
          if ((i % c) == (c / 2) && bitn < 10) obs[bitn] = txv;
        end
        if (!aborted) begin
          check($sformatf("frame_bits_dut%0d", which), {22'd0, obs}, {22'd0, 1'b1, d, 1'b0});
          check($sformatf("cycle_bits_dut%0d", which), bad, 0);
          if (which == 0) last_low_a = low;
        end
        if (which == 0) mon_busy_a = 1'b0; else mon_busy_b = 1'b0;
      end
    end
  endtask

  initial mon(0, 32, 1);
  initial mon(1, 4, 0);

  // Offer one byte until accepted; returns the accepting edge number.
  task automatic push(input int which, input logic [7:0] d, output int n);
    n = -1;
    if (which == 0) begin pv_a = 1'b1; pd_a = d; end else begin pv_b = 1'b1; pd_b = d; end
    for (int t = 0; t < 8000; t++) begin
      if (((which == 0) ? pr_a : pr_b) === 1'b1) begin
        @(negedge clk);
        n = cyc;
        if (which == 0) qa.push_back(d); else qb.push_back(d);
        break;
      end
      @(negedge clk);
    end
    if (which == 0) pv_a = 1'b0; else pv_b = 1'b0;
    if (n < 0) begin
      vectors++;
      miscompares++;
      $error("FAIL push_timeout: dut %0d never accepted %0h, required acceptance", which, d);
    end
  endtask

  task automatic wait_idle(input int which, input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (which == 0 && qa.size() == 0 && busy_a === 1'b0 && !mon_busy_a) return;
      if (which == 1 && qb.size() == 0 && busy_b === 1'b0 && !mon_busy_b) return;
    end
    vectors++;
    miscompares++;
    $error("FAIL idle_timeout: dut %0d still busy after %0d cycles, required idle", which, budget);
  endtask

  initial begin
    int n, n0, s, target;
    int edges[20];
    rst_a = 1'b1; rst_b = 1'b1;
    pv_a = 1'b0; pv_b = 1'b0; pd_a = 8'h00; pd_b = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_count", cnt_a, 0);
    check("reset_ready", pr_a, 0);
    check("reset_tx_b", tx_b, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("ready_after_reset", pr_a, 1);

    // Single 0xA5: latency and busy duration
    push(0, 8'hA5, n);
    check("a5_tx_before_pop", tx_a, 1);
    @(negedge clk);
    check("a5_tx_falls_n1", tx_a, 0);
    check("a5_busy", busy_a, 1);
    check("a5_count_after_pop", cnt_a, 0);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy_a === 1'b0) break;
    end
    check("a5_busy_fall_cycle", cyc - n, 353);
    wait_idle(0, 100);

    // Corner bytes
    push(0, 8'h00, n);
    wait_idle(0, 500);
    check("zero_low_cycles", last_low_a, 9 * 32);
    push(0, 8'hFF, n);
    wait_idle(0, 500);
    check("ff_low_cycles", last_low_a, 32);

    // Back-to-back spacing
    starts_a.delete();
    push(0, 8'h3C, n);
    push(0, 8'hC3, n);
    wait_idle(0, 1000);
    check("b2b_frames", starts_a.size(), 2);
    if (starts_a.size() == 2) check("b2b_spacing", starts_a[1] - starts_a[0], 352);

    // Overflow: ramp held valid
    for (int i = 0; i < 20; i++) begin
      push(0, 8'(i), edges[i]);
      if (i == 16) begin
        check("ovf_count_full", cnt_a, 16);
        check("ovf_ready_low", pr_a, 0);
        check("ovf_no_stall", edges[16] - edges[0], 16);
      end
    end
    wait_idle(0, 8000);

    // Reset during data bit 3 with bytes queued
    push(0, 8'h00, n0);
    push(0, 8'h11, n);
    push(0, 8'h22, n);
    push(0, 8'h33, n);
    s = n0 + 1;
    target = s + 4 * 32 + 10;
    for (int t = 0; t < 400 && cyc < target; t++) @(negedge clk);
    check("rst_pre_tx_low", tx_a, 0);
    rst_a = 1'b1;
    qa.delete();
    @(negedge clk);
    check("rst_tx_high", tx_a, 1);
    check("rst_busy_low", busy_a, 0);
    check("rst_count_zero", cnt_a, 0);
    check("rst_ready_low", pr_a, 0);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_resume", busy_a, 0);
    push(0, 8'h5A, n);
    wait_idle(0, 500);

    // Small variant: three frames 40 cycles apart
    push(1, 8'h96, n);
    push(1, 8'h01, n);
    push(1, 8'hE7, n);
    wait_idle(1, 300);
    check("var_frames", starts_b.size(), 3);
    if (starts_b.size() == 3) begin
      check("var_spacing_1", starts_b[1] - starts_b[0], 40);
      check("var_spacing_2", starts_b[2] - starts_b[1], 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
